instr_encoder: RTL and testbench

Assembles RV32I and custom-quantum instruction words from individual fields, the inverse of the instruction decoder's field split and immediate extraction. A field bundle is checked so its immediate is representable in the opcode's format, then packed into a 32-bit word and buffered in a small FIFO. It feeds the instruction-injection path used by the debug/program-load logic and the round-trip decode checkers. Illegal immediates are dropped and counted.

---
 rtl/instr_encoder_if.sv | 28 ++
 rtl/instr_encoder.sv | 177 +++++++++++++++++
 tb/tb_instr_encoder.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_if.sv
// Field-bundle input and packed-word output handshakes of the instruction encoder.
// Both sides are valid/ready: a transfer happens on a rising clk edge where valid && ready.
interface instr_encoder_if;
   logic        in_valid;
   logic        in_ready;
   logic [6:0]  in_opcode;
   logic [2:0]  in_funct3;
   logic [6:0]  in_funct7;
   logic [4:0]  in_rd;
   logic [4:0]  in_rs1;
   logic [4:0]  in_rs2;
   logic [31:0] in_imm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;

   modport master (
      output in_valid, in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm,
      output out_ready,
      input  in_ready, out_valid, out_instr
   );

   modport slave (
      input  in_valid, in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm,
      input  out_ready,
      output in_ready, out_valid, out_instr
   );
endinterface

// File: rtl/instr_encoder.sv
// Packs RV32I / custom-quantum field bundles into 32-bit words after an immediate
// range check, and queues legal words in a DEPTH-entry FIFO; illegal ones are counted.
module instr_encoder #(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   instr_encoder_if.slave             bus,
   output logic                       err_imm,
   output logic [7:0]                 err_count,
   output logic [15:0]                emit_count,
   output logic [$clog2(DEPTH+1)-1:0] level
);
   localparam int LW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [6:0] OPC_LUI     = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
   localparam logic [6:0] OPC_JAL     = 7'b1101111;
   localparam logic [6:0] OPC_JALR    = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
   localparam logic [6:0] OPC_LOAD    = 7'b0000011;
   localparam logic [6:0] OPC_STORE   = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM  = 7'b0010011;
   localparam logic [6:0] OPC_QUANTUM = 7'b0001011;

   typedef enum logic [2:0] {
      FMT_R,
      FMT_I,
      FMT_S,
      FMT_B,
      FMT_U,
      FMT_J
   } fmt_e;

   fmt_e              w_fmt;
   logic [31:0]       w_imm;
   logic [31:0]       w_word;
   logic              w_legal;
   logic              w_i_ok;
   logic              w_b_ok;
   logic              w_j_ok;
   logic              w_u_ok;
   logic              w_full;
   logic              w_empty;
   logic              w_accept;
   logic              w_push;
   logic              w_drop;
   logic              w_pop;

   logic [31:0]       r_mem [DEPTH];
   logic [PW-1:0]     r_wr_ptr;
   logic [PW-1:0]     r_rd_ptr;
   logic [LW-1:0]     r_level;
   logic              r_err_imm;
   logic [7:0]        r_err_count;
   logic [15:0]       r_emit_count;

   always_comb begin
      w_fmt = FMT_R;
      case (bus.in_opcode)
         OPC_LUI, OPC_AUIPC:                      w_fmt = FMT_U;
         OPC_JAL:                                 w_fmt = FMT_J;
         OPC_BRANCH:                              w_fmt = FMT_B;
         OPC_STORE:                               w_fmt = FMT_S;
         OPC_OP_IMM, OPC_LOAD, OPC_JALR,
         OPC_QUANTUM:                             w_fmt = FMT_I;
         default:                                 w_fmt = FMT_R;
      endcase
   end

   // Each range test asks whether the upper bits are pure sign extension.
   assign w_imm  = bus.in_imm;
   assign w_i_ok = (&w_imm[31:11]) | ~(|w_imm[31:11]);
   assign w_b_ok = ((&w_imm[31:12]) | ~(|w_imm[31:12])) & ~w_imm[0];
   assign w_j_ok = ((&w_imm[31:20]) | ~(|w_imm[31:20])) & ~w_imm[0];
   assign w_u_ok = ~(|w_imm[11:0]);

   always_comb begin
      w_word  = '0;
      w_legal = 1'b1;
      case (w_fmt)
         FMT_I: begin
            w_word  = {w_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
            w_legal = w_i_ok;
         end
         FMT_S: begin
            w_word  = {w_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                       w_imm[4:0], bus.in_opcode};
            w_legal = w_i_ok;
         end
         FMT_B: begin
            w_word  = {w_imm[12], w_imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                       w_imm[4:1], w_imm[11], bus.in_opcode};
            w_legal = w_b_ok;
         end
         FMT_U: begin
            w_word  = {w_imm[31:12], bus.in_rd, bus.in_opcode};
            w_legal = w_u_ok;
         end
         FMT_J: begin
            w_word  = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12],
                       bus.in_rd, bus.in_opcode};
            w_legal = w_j_ok;
         end
         default: begin
            w_word  = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3,
                       bus.in_rd, bus.in_opcode};
            w_legal = 1'b1;
         end
      endcase
   end

   // No pass-through: in_ready depends only on registered level and flush.
   assign w_full        = (r_level == LW'(DEPTH));
   assign w_empty       = (r_level == '0);
   assign bus.in_ready  = ~w_full & ~flush;
   assign w_accept      = bus.in_valid & bus.in_ready;
   assign w_push        = w_accept & w_legal;
   assign w_drop        = w_accept & ~w_legal;
   assign w_pop         = ~w_empty & bus.out_ready & ~flush;

   assign bus.out_valid = ~w_empty;
   assign bus.out_instr = w_empty ? 32'd0 : r_mem[r_rd_ptr];
   assign err_imm       = r_err_imm;
   assign err_count     = r_err_count;
   assign emit_count    = r_emit_count;
   assign level         = r_level;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_word;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   // Counters survive flush; only reset clears them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err_imm    <= 1'b0;
         r_err_count  <= '0;
         r_emit_count <= '0;
      end else begin
         r_err_imm <= w_drop;
         if (w_drop && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
         end
         if (w_pop) begin
            r_emit_count <= r_emit_count + 16'd1;
         end
      end
   end
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a bundle-queue model checked every cycle by
// decoding the head word, plus literal words and counter values for key cases.
module tb_instr_encoder;
   localparam int DEPTH = 4;

   localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111;
   localparam logic [6:0] JALR = 7'b1100111, BRANCH = 7'b1100011, LOAD = 7'b0000011;
   localparam logic [6:0] STORE = 7'b0100011, OP_IMM = 7'b0010011, QUANT = 7'b0001011;
   localparam logic [6:0] OP = 7'b0110011;

   typedef struct packed {
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
   } bundle_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        err_imm;
   logic [7:0]  err_count;
   logic [15:0] emit_count;
   logic [2:0]  level;

   int n_checks = 0;
   int n_errors = 0;

   logic [63:0] exp_q[$];
   logic        m_err = 1'b0;
   int          m_errc = 0;
   logic [15:0] m_emit = '0;

   instr_encoder_if bus();

   instr_encoder #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .bus        (bus),
      .err_imm    (err_imm),
      .err_count  (err_count),
      .emit_count (emit_count),
      .level      (level)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // 0=R 1=I 2=S 3=B 4=U 5=J
   function automatic int fmt_of(input logic [6:0] op);
      if (op == LUI || op == AUIPC) return 4;
      if (op == JAL) return 5;
      if (op == BRANCH) return 3;
      if (op == STORE) return 2;
      if (op == OP_IMM || op == LOAD || op == JALR || op == QUANT) return 1;
      return 0;
   endfunction

   function automatic bit legal(input bundle_t b);
      int v;
      v = $signed(b.imm);
      case (fmt_of(b.op))
         1, 2:    return (v >= -2048) && (v <= 2047);
         3:       return (v >= -4096) && (v <= 4095) && !b.imm[0];
         5:       return (v >= -1048576) && (v <= 1048575) && !b.imm[0];
         4:       return (b.imm % 32'd4096) == 0;
         default: return 1'b1;
      endcase
   endfunction

   // Decodes the word the way the instruction decoder would and compares fields.
   function automatic bit round_trip_ok(input logic [31:0] w, input bundle_t b);
      logic [31:0] imm;
      if (w[6:0] != b.op) return 1'b0;
      case (fmt_of(b.op))
         1: begin
            imm = {{20{w[31]}}, w[31:20]};
            return w[14:12] == b.f3 && w[11:7] == b.rd && w[19:15] == b.rs1 && imm == b.imm;
         end
         2: begin
            imm = {{20{w[31]}}, w[31:25], w[11:7]};
            return w[14:12] == b.f3 && w[19:15] == b.rs1 && w[24:20] == b.rs2 && imm == b.imm;
         end
         3: begin
            imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            return w[14:12] == b.f3 && w[19:15] == b.rs1 && w[24:20] == b.rs2 && imm == b.imm;
         end
         4: begin
            imm = {w[31:12], 12'd0};
            return w[11:7] == b.rd && imm == b.imm;
         end
         5: begin
            imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            return w[11:7] == b.rd && imm == b.imm;
         end
         default:
            return w[14:12] == b.f3 && w[11:7] == b.rd && w[19:15] == b.rs1 &&
                   w[24:20] == b.rs2 && w[31:25] == b.f7;
      endcase
   endfunction

   function automatic bundle_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                  input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                  input logic [31:0] imm);
      return '{op: op, f3: f3, f7: f7, rd: rd, rs1: rs1, rs2: rs2, imm: imm};
   endfunction

   // Compare process: check outputs against the model, then advance it to the next edge.
   always @(negedge clk) begin
      bundle_t b;
      bundle_t h;
      bit      acc;
      bit      pop;
      bit      leg;
      if (!rst_n) begin
         exp_q.delete();
         m_err  = 1'b0;
         m_errc = 0;
         m_emit = '0;
      end
      chk("level", 32'(level), 32'(exp_q.size()));
      chk("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
      chk("in_ready", 32'(bus.in_ready), 32'((exp_q.size() < DEPTH) && !flush));
      chk("err_imm", 32'(err_imm), 32'(m_err));
      chk("err_count", 32'(err_count), 32'(m_errc));
      chk("emit_count", 32'(emit_count), 32'(m_emit));
      if (exp_q.size() == 0) begin
         chk("out_instr_idle", bus.out_instr, 32'd0);
      end else begin
         h = bundle_t'(exp_q[0]);
         n_checks++;
         if (!round_trip_ok(bus.out_instr, h)) begin
            n_errors++;
            $display("FAIL round_trip: got word %h expected op=%h f3=%h f7=%h rd=%0d rs1=%0d rs2=%0d imm=%h",
                     bus.out_instr, h.op, h.f3, h.f7, h.rd, h.rs1, h.rs2, h.imm);
         end
      end
      if (rst_n) begin
         b   = mk(bus.in_opcode, bus.in_funct3, bus.in_funct7, bus.in_rd, bus.in_rs1,
                  bus.in_rs2, bus.in_imm);
         acc = bus.in_valid && (exp_q.size() < DEPTH) && !flush;
         pop = (exp_q.size() != 0) && bus.out_ready && !flush;
         leg = legal(b);
         if (flush) begin
            exp_q.delete();
         end else begin
            if (pop) begin
               void'(exp_q.pop_front());
               m_emit = m_emit + 16'd1;
            end
            if (acc && leg) exp_q.push_back(64'(b));
         end
         m_err = acc && !leg;
         if (acc && !leg && m_errc < 255) m_errc++;
      end
   end

   task automatic drive(input bundle_t b);
      bus.in_opcode = b.op;
      bus.in_funct3 = b.f3;
      bus.in_funct7 = b.f7;
      bus.in_rd     = b.rd;
      bus.in_rs1    = b.rs1;
      bus.in_rs2    = b.rs2;
      bus.in_imm    = b.imm;
   endtask

   // Returns at #1 after the accepting edge.
   task automatic send(input bundle_t b);
      bit ok;
      ok = 1'b0;
      @(posedge clk); #1;
      drive(b);
      bus.in_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_checks++;
         n_errors++;
         $display("FAIL send_timeout: in_ready stayed 0 expected 1");
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      bit ok;
      ok = 1'b0;
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (level == 3'd0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_checks++;
         n_errors++;
         $display("FAIL drain_timeout: level %0d expected 0", level);
      end
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
      chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
      chk({tag, "_out_instr"}, bus.out_instr, 32'd0);
      chk({tag, "_err_imm"}, 32'(err_imm), 32'd0);
      chk({tag, "_err_count"}, 32'(err_count), 32'd0);
      chk({tag, "_emit_count"}, 32'(emit_count), 32'd0);
      chk({tag, "_level"}, 32'(level), 32'd0);
   endtask

   initial begin
      bit ok;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      drive(mk(OP, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0));
      repeat (3) @(posedge clk);
      #1;
      chk_reset_values("reset");
      rst_n = 1'b1;

      // ADDI x1, x2, -1
      send(mk(OP_IMM, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFF));
      chk("addi_valid", 32'(bus.out_valid), 32'd1);
      chk("addi_word", bus.out_instr, 32'hFFF1_0093);
      drain();

      send(mk(BRANCH, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8));
      chk("beq_word", bus.out_instr, 32'h0020_8463);
      drain();

      send(mk(BRANCH, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3));
      chk("beq_odd_err_imm", 32'(err_imm), 32'd1);
      chk("beq_odd_err_count", 32'(err_count), 32'd1);
      chk("beq_odd_level", 32'(level), 32'd0);
      @(posedge clk); #1;
      chk("beq_odd_pulse_end", 32'(err_imm), 32'd0);

      send(mk(LUI, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000));
      chk("lui_word", bus.out_instr, 32'h1234_52B7);
      drain();

      // Back-to-back illegal LUI then JAL: err_imm held high across both.
      @(posedge clk); #1;
      drive(mk(LUI, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5001));
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      drive(mk(JAL, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h0010_0000));
      chk("b2b_err_imm_1", 32'(err_imm), 32'd1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      chk("b2b_err_imm_2", 32'(err_imm), 32'd1);
      chk("b2b_err_count", 32'(err_count), 32'd3);
      chk("b2b_level", 32'(level), 32'd0);
      @(posedge clk); #1;
      chk("b2b_pulse_end", 32'(err_imm), 32'd0);

      // Fill to DEPTH with out_ready low; fifth bundle waits for the first pop.
      send(mk(AUIPC, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 32'hFFFF_F000));
      send(mk(STORE, 3'd2, 7'd0, 5'd0, 5'd3, 5'd4, 32'hFFFF_FFFC));
      send(mk(BRANCH, 3'd1, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_F000));
      send(mk(JAL, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_F800));
      drive(mk(QUANT, 3'd5, 7'd0, 5'd9, 5'd10, 5'd0, 32'h0000_07FF));
      bus.in_valid = 1'b1;
      @(negedge clk);
      chk("full_level", 32'(level), 32'd4);
      chk("full_in_ready", 32'(bus.in_ready), 32'd0);
      repeat (2) @(negedge clk);
      chk("full_held", 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      chk("full_fifth_accepted", 32'(ok), 32'd1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      drain();
      chk("fill_emit_count", 32'(emit_count), 32'd8);
      chk("fill_level", 32'(level), 32'd0);

      // Flush at level 3 with a push and a pop requested.
      send(mk(OP, 3'd0, 7'h20, 5'd6, 5'd7, 5'd8, 32'd0));
      send(mk(OP, 3'd7, 7'h01, 5'd11, 5'd12, 5'd13, 32'hDEAD_BEEF));
      send(mk(JALR, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'hFFFF_F800));
      chk("pre_flush_level", 32'(level), 32'd3);
      @(posedge clk); #1;
      flush = 1'b1;
      drive(mk(OP_IMM, 3'd0, 7'd0, 5'd1, 5'd1, 5'd0, 32'd1));
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      #1;
      chk("flush_in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
      flush = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      chk("flush_level", 32'(level), 32'd0);
      chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
      chk("flush_emit_count", 32'(emit_count), 32'd8);

      // Reset mid-stream with level 2 and err_count 7.
      for (int i = 0; i < 4; i++) begin
         send(mk(OP_IMM, 3'd0, 7'd0, 5'd1, 5'd1, 5'd0, 32'h0000_0800));
      end
      send(mk(OP, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0));
      send(mk(STORE, 3'd0, 7'd0, 5'd0, 5'd4, 5'd5, 32'h0000_07FF));
      chk("pre_reset_level", 32'(level), 32'd2);
      chk("pre_reset_err_count", 32'(err_count), 32'd7);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk_reset_values("midreset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      send(mk(LOAD, 3'd2, 7'd0, 5'd5, 5'd6, 5'd0, 32'd16));
      chk("post_reset_word", bus.out_instr, 32'h0103_2283);
      drain();
      chk("post_reset_emit", 32'(emit_count), 32'd1);

      // err_count saturates at 255.
      @(posedge clk); #1;
      drive(mk(JAL, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1));
      bus.in_valid = 1'b1;
      repeat (260) @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      chk("err_count_saturated", 32'(err_count), 32'd255);

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
